cla_prefix_pipe: RTL
====================

// Module: cla_prefix_pipe
// PURPOSE
//  Parametrised pipelined parallel-prefix (Kogge-Stone) carry-lookahead adder/subtractor.
//  Generalises the fixed 16-bit pipelined CLA to any width, with configurable pipeline
//  depth, per-operation add/sub mode, carry-in, and a valid/ready handshake with backpressure.
//  Sits between the operand-issue logic and the result-writeback stage of the ALU datapath.
// PARAMETERS
//  WIDTH   16  operand width in bits; any value >= 2 (prefix tree has ceil(log2(WIDTH)) levels)
//  STAGES  4   pipeline register stages, 1..ceil(log2(WIDTH))+1; latency = STAGES cycles
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous active-low reset
//  in_valid   in   1        operand beat valid
//  in_ready   out  1        block can accept a beat this cycle
//  a          in   WIDTH    operand A (unsigned or two's complement)
//  b          in   WIDTH    operand B
//  cin        in   1        carry-in (add mode only; ignored in sub mode)
//  sub        in   1        0: a+b+cin   1: a-b (= a + ~b + 1)
//  out_valid  out  1        result valid
//  out_ready  in   1        downstream accepts result
//  out        out  WIDTH+1  {carry_out, sum}; sub mode: out[WIDTH]=1 means no borrow (a>=b unsigned)
// BEHAVIOUR
//  - Reset (rst_n=0, async): all valid bits clear -> out_valid=0, out=0; in_ready=1 after
//    reset since pipe is empty. Data registers may reset to 0; out must read 0 while in reset.
//  - Stage 0 forms g=a&b', p=a^b' (b'=sub?~b:b), c0=sub?1:cin. Prefix levels are spread
//    evenly over STAGES register slices (earliest slices take the extra level if uneven);
//    final slice computes sum=p^{carries,c0} and carry_out=carry[WIDTH].
//  - Latency: beat accepted at edge N (in_valid&in_ready) appears with out_valid=1 after
//    edge N+STAGES-1, i.e. STAGES cycles from acceptance to visibility when never stalled.
//  - Throughput: one beat per cycle. Bubbles (in_valid=0) travel as valid=0 slots.
//  - Stall: stall = out_valid & ~out_ready. While stall=1 every stage register (data and valid)
//    holds; in_ready = ~stall. No beat is dropped or duplicated; out/out_valid stable during stall.
//  - Handshake: result consumed on out_valid&out_ready. in_ready combinationally depends on
//    out_ready only (no dependency on in_valid).
//  - Wrap-around: arithmetic is modulo 2^WIDTH in sum; overflow goes only to out[WIDTH].
//  - Boundaries: a=b=all-ones, cin=1 -> out=all-ones of WIDTH+1; sub with a=b -> sum=0,
//    carry=1; sub with a=0,b=1 -> sum=all-ones, carry=0.
//  - Reset mid-operation: all in-flight beats discarded, no result emitted for them.
//  - Simultaneous in_valid and stall: beat is not accepted (in_ready=0); source must hold.
// CONFIGURATION
//  CLA_PREFIX_OVF_EN defined: adds output ovf (1 bit), pipelined alongside out:
//    ovf = signed two's-complement overflow = carry[WIDTH] ^ carry[WIDTH-1]; resets to 0,
//    holds on stall, valid only with out_valid.
//  Not defined: port ovf absent; no extra registers; all other behaviour identical.
// TESTING  (WIDTH=16, STAGES=4 unless noted)
//  1 a=0xFFFF,b=0xFFFF,cin=0,sub=0 at cycle 0, out_ready=1 -> out=0x1FFFE, out_valid
//    exactly 4 cycles later; then a=38,b=12 -> 50; a=111,b=121 -> 232, back-to-back.
//  2 sub=1: a=38,b=12 -> out=0x1001A; a=12,b=38 -> out=0x0FFE6 (borrow); a=b=0x8000 -> 0x10000.
//  3 stream 8 beats, drop out_ready for 3 cycles mid-stream -> in_ready=0 those cycles, out
//    held stable, all 8 results emitted in order, none lost or repeated.
//  4 reset asserted with 3 beats in flight -> out_valid=0, out=0 immediately (async);
//    after release first new beat appears after 4 cycles, stale beats never appear.
//  5 sweep WIDTH=8/STAGES=1, WIDTH=32/STAGES=6, WIDTH=13/STAGES=3 with 1000 random a,b,cin,sub
//    -> every out matches {1'b0,a}+{1'b0,b'}+c0 reference model, latency = STAGES.
//  6 CLA_PREFIX_OVF_EN: 0x7FFF+0x0001 -> ovf=1; 0x8000-0x0001 -> ovf=1; 0x0005+0x0003 -> ovf=0.

Source files
------------

// File: rtl/cla_prefix_pipe.sv
// ---------------------------------------------------------------------------
// cla_prefix_pipe
//
// Pipelined parallel-prefix (Kogge-Stone) carry-lookahead adder/subtractor of
// arbitrary width. The prefix tree levels are spread over STAGES register
// slices. A valid/ready handshake with full backpressure lets the whole pipe
// freeze when the downstream consumer is not ready.
//
// Parameters
//   WIDTH   operand width in bits (>= 2)
//   STAGES  number of register slices, 1 .. ceil(log2(WIDTH))+1 ; latency = STAGES
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand beat valid
//   in_ready   out  block accepts a beat this cycle
//   a, b       in   operands (WIDTH bits)
//   cin        in   carry-in, add mode only
//   sub        in   0: a+b+cin   1: a-b
//   out_valid  out  result valid
//   out_ready  in   downstream accepts result
//   out        out  {carry_out, sum} (WIDTH+1 bits); in sub mode the top bit
//                   set means no borrow
//   ovf        out  signed overflow flag, present only when the macro
//                   CLA_PREFIX_OVF_EN is defined
// ---------------------------------------------------------------------------
module cla_prefix_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out
`ifdef CLA_PREFIX_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int LEVELS = $clog2(WIDTH);
  // Levels per slice; the first EXTRA slices carry one more level each.
  localparam int BASE   = LEVELS / STAGES;
  localparam int EXTRA  = LEVELS % STAGES;

  logic stall;
  logic advance;

  // The only thing that can freeze the pipe is a result nobody takes.
  assign stall    = out_valid & ~out_ready;
  assign advance  = ~stall;
  assign in_ready = ~stall;

  // Applies the Kogge-Stone levels [first, first+count) to a generate /
  // propagate pair. After all levels, g[i]/p[i] describe the group [i:0].
  function automatic logic [2*WIDTH-1:0] prefix_levels(
    input logic [WIDTH-1:0] g,
    input logic [WIDTH-1:0] p,
    input int               first,
    input int               count
  );
    logic [WIDTH-1:0] gc;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] gn;
    logic [WIDTH-1:0] pn;
    gc = g;
    pc = p;
    for (int lv = 0; lv < LEVELS; lv++) begin
      if (lv >= first && lv < first + count) begin
        gn = gc;
        pn = pc;
        for (int i = 0; i < WIDTH; i++) begin
          if (i >= (1 << lv)) begin
            gn[i] = gc[i] | (pc[i] & gc[i - (1 << lv)]);
            pn[i] = pc[i] & pc[i - (1 << lv)];
          end
        end
        gc = gn;
        pc = pn;
      end
    end
    return {gc, pc};
  endfunction

  for (genvar s = 0; s < STAGES; s++) begin : slice
    localparam int FIRST = s * BASE + ((s < EXTRA) ? s : EXTRA);
    localparam int COUNT = BASE + ((s < EXTRA) ? 1 : 0);

    logic [WIDTH-1:0] g_in;
    logic [WIDTH-1:0] p_in;
    logic [WIDTH-1:0] x_in;
    logic             c0_in;
    logic             v_in;
    logic [WIDTH-1:0] g_lv;
    logic [WIDTH-1:0] p_lv;
    logic             v_q;

    if (s == 0) begin : src
      logic [WIDTH-1:0] b_eff;
      // Subtraction is a + ~b + 1, so the +1 rides in as the carry-in and
      // the external cin is ignored.
      assign b_eff = sub ? ~b : b;
      assign g_in  = a & b_eff;
      assign p_in  = a ^ b_eff;
      assign x_in  = a ^ b_eff;
      assign c0_in = sub ? 1'b1 : cin;
      assign v_in  = in_valid;
    end else begin : chain
      assign g_in  = slice[s-1].hold.g_q;
      assign p_in  = slice[s-1].hold.p_q;
      assign x_in  = slice[s-1].hold.x_q;
      assign c0_in = slice[s-1].hold.c0_q;
      assign v_in  = slice[s-1].v_q;
    end

    always_comb begin
      {g_lv, p_lv} = prefix_levels(g_in, p_in, FIRST, COUNT);
    end

    // Valid bit of this slice; bubbles move along as zeros and everything
    // freezes together during a stall.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
      end else if (advance) begin
        v_q <= v_in;
      end
    end

    if (s < STAGES - 1) begin : hold
      logic [WIDTH-1:0] g_q;
      logic [WIDTH-1:0] p_q;
      logic [WIDTH-1:0] x_q;
      logic             c0_q;

      // Intermediate prefix state; x keeps the raw half-sum for the final XOR.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          g_q  <= '0;
          p_q  <= '0;
          x_q  <= '0;
          c0_q <= 1'b0;
        end else if (advance) begin
          g_q  <= g_lv;
          p_q  <= p_lv;
          x_q  <= x_in;
          c0_q <= c0_in;
        end
      end
    end else begin : finish
      logic [WIDTH:0] carry;
      logic [WIDTH:0] result;
      logic [WIDTH:0] out_q;

      // Carry into bit i+1 is the group generate of [i:0] or the group
      // propagate of [i:0] passing the initial carry through.
      always_comb begin
        carry[0] = c0_in;
        for (int i = 0; i < WIDTH; i++) begin
          carry[i+1] = g_lv[i] | (p_lv[i] & c0_in);
        end
      end

      assign result = {carry[WIDTH], x_in ^ carry[WIDTH-1:0]};

      // Output register; reads zero throughout reset.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_q <= '0;
        end else if (advance) begin
          out_q <= result;
        end
      end

      assign out       = out_q;
      assign out_valid = v_q;

`ifdef CLA_PREFIX_OVF_EN
      logic ovf_q;

      // Signed overflow: carry into the sign bit differs from carry out of it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (advance) begin
          ovf_q <= carry[WIDTH] ^ carry[WIDTH-1];
        end
      end

      assign ovf = ovf_q;
`endif
    end
  end

endmodule
